// File: rtl/lfsr_seq_checker.sv
// Self-synchronising checker for the 8-bit maximal-length LFSR stream.
// Locks onto the sequence, flywheels through isolated errors, counts them and measures the period.
module lfsr_seq_checker #(
  parameter logic [7:0]  TAPS         = 8'hB8,
  parameter int unsigned LOCK_MATCHES = 4,
  parameter int unsigned LOSS_ERRORS  = 3,
  parameter int unsigned ERR_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [8:0]       period,
  output logic             period_vld,
  output logic             zero_seen
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned PER_W = 9;
  localparam logic [PER_W-1:0] PER_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOCK
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       prev, prev_nxt;
  logic [7:0]       ref_word, ref_word_nxt;
  logic [CNT_W-1:0] match_cnt, match_cnt_nxt;
  logic [CNT_W-1:0] miss_cnt, miss_cnt_nxt;
  logic [PER_W-1:0] per_cnt, per_cnt_nxt;
  logic             locked_nxt, err_pulse_nxt, period_vld_nxt, zero_seen_nxt;
  logic [ERR_W-1:0] err_count_nxt;
  logic [PER_W-1:0] period_nxt;

  logic [7:0]       pred;
  logic             hit;
  logic [CNT_W-1:0] match_inc, miss_inc;
  logic [PER_W-1:0] per_inc;

  assign pred      = {prev[6:0], ^(prev & TAPS)};
  assign hit       = (in_data == pred) && (in_data != 8'h00);
  assign match_inc = match_cnt + CNT_W'(1);
  assign miss_inc  = miss_cnt + CNT_W'(1);
  assign per_inc   = (per_cnt == PER_MAX) ? per_cnt : per_cnt + PER_W'(1);

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    ref_word_nxt   = ref_word;
    match_cnt_nxt  = match_cnt;
    miss_cnt_nxt   = miss_cnt;
    per_cnt_nxt    = per_cnt;
    err_count_nxt  = err_count;
    period_nxt     = period;
    zero_seen_nxt  = zero_seen;
    err_pulse_nxt  = 1'b0;
    period_vld_nxt = 1'b0;

    if (in_valid) begin
      if (in_data == 8'h00) zero_seen_nxt = 1'b1;
      case (state)
        ST_IDLE: begin
          prev_nxt      = in_data;
          match_cnt_nxt = '0;
          state_nxt     = ST_SYNC;
        end
        ST_SYNC: begin
          prev_nxt      = in_data;
          match_cnt_nxt = hit ? match_inc : '0;
          if (hit && (match_inc == CNT_W'(LOCK_MATCHES))) begin
            state_nxt    = ST_LOCK;
            ref_word_nxt = in_data;
            per_cnt_nxt  = '0;
            miss_cnt_nxt = '0;
          end
        end
        ST_LOCK: begin
          per_cnt_nxt = per_inc;
          if (hit) begin
            prev_nxt     = in_data;
            miss_cnt_nxt = '0;
            if (in_data == ref_word) begin
              period_nxt     = per_inc;
              period_vld_nxt = 1'b1;
              per_cnt_nxt    = '0;
            end
          end else begin
            // Flywheel: keep predicting from our own model through isolated errors.
            prev_nxt      = pred;
            err_pulse_nxt = 1'b1;
            if (err_count != ERR_MAX) err_count_nxt = err_count + ERR_W'(1);
            miss_cnt_nxt  = miss_inc;
            if (miss_inc == CNT_W'(LOSS_ERRORS)) begin
              state_nxt     = ST_SYNC;
              match_cnt_nxt = '0;
              prev_nxt      = in_data;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    if (clear_err) begin
      err_count_nxt = '0;
      zero_seen_nxt = 1'b0;
    end

    locked_nxt = (state_nxt == ST_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev       <= '0;
      ref_word   <= '0;
      match_cnt  <= '0;
      miss_cnt   <= '0;
      per_cnt    <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      zero_seen  <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      ref_word   <= ref_word_nxt;
      match_cnt  <= match_cnt_nxt;
      miss_cnt   <= miss_cnt_nxt;
      per_cnt    <= per_cnt_nxt;
      locked     <= locked_nxt;
      err_pulse  <= err_pulse_nxt;
      err_count  <= err_count_nxt;
      period     <= period_nxt;
      period_vld <= period_vld_nxt;
      zero_seen  <= zero_seen_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Scoreboard bench for lfsr_seq_checker: directed scenarios plus a randomized stream,
// compared against a sample-level reference model.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clear_err = 1'b0;
  logic        locked, err_pulse, period_vld, zero_seen;
  logic [15:0] err_count;
  logic [8:0]  period;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [8:0]  per;
    logic        pv;
    logic        zs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lfsr_seq_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clear_err  (clear_err),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .period     (period),
    .period_vld (period_vld),
    .zero_seen  (zero_seen)
  );

  function automatic logic [7:0] nxt(input logic [7:0] w);
    return {w[6:0], ^(w & 8'hB8)};
  endfunction

  // Reference model: one call per sampled clock edge.
  localparam int M_IDLE = 0, M_SYNC = 1, M_LOCK = 2;
  int         m_mode, m_mcnt, m_miss, m_pcnt;
  logic [7:0] m_prev, m_ref;
  exp_t       m_out;

  task automatic m_reset();
    m_mode = M_IDLE; m_mcnt = 0; m_miss = 0; m_pcnt = 0;
    m_prev = 8'h00; m_ref = 8'h00; m_out = '0;
  endtask

  task automatic m_step(input logic v, input logic [7:0] d, input logic c);
    logic [7:0] p;
    bit hit;
    int seen;
    m_out.ep = 1'b0;
    m_out.pv = 1'b0;
    if (v) begin
      p    = nxt(m_prev);
      hit  = (d == p) && (d != 8'h00);
      seen = (m_pcnt + 1 > 511) ? 511 : m_pcnt + 1;
      if (d == 8'h00) m_out.zs = 1'b1;
      if (m_mode == M_IDLE) begin
        m_prev = d; m_mcnt = 0; m_mode = M_SYNC;
      end else if (m_mode == M_SYNC) begin
        m_mcnt = hit ? m_mcnt + 1 : 0;
        m_prev = d;
        if (m_mcnt == 4) begin
          m_mode = M_LOCK; m_ref = d; m_pcnt = 0; m_miss = 0;
        end
      end else begin
        m_pcnt = seen;
        if (hit) begin
          m_prev = d; m_miss = 0;
          if (d == m_ref) begin
            m_out.per = 9'(seen); m_out.pv = 1'b1; m_pcnt = 0;
          end
        end else begin
          m_prev = p;
          m_out.ep = 1'b1;
          if (m_out.ec != 16'hFFFF) m_out.ec = m_out.ec + 16'd1;
          m_miss++;
          if (m_miss == 3) begin
            m_mode = M_SYNC; m_mcnt = 0; m_prev = d;
          end
        end
      end
    end
    if (c) begin
      m_out.ec = 16'h0000;
      m_out.zs = 1'b0;
    end
    m_out.lk = (m_mode == M_LOCK);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Drive one cycle, advance the model at the sampling edge, queue the expected response.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    clear_err = c;
    @(posedge clk);
    m_step(v, d, c);
    sb.push_back(m_out);
    #1;
  endtask

  logic [7:0] cur;

  task automatic send(input logic [7:0] flip, input logic c);
    step(1'b1, cur ^ flip, c);
    cur = nxt(cur);
  endtask

  task automatic idle();
    step(1'b0, 8'($urandom), 1'b0);
  endtask

  // Monitor: compare every registered response one edge after it was produced.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({locked, err_pulse, err_count, period, period_vld, zero_seen} !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got lk=%0b ep=%0b ec=%0d per=%0d pv=%0b zs=%0b expected lk=%0b ep=%0b ec=%0d per=%0d pv=%0b zs=%0b",
                   $time, locked, err_pulse, err_count, period, period_vld, zero_seen,
                   e.lk, e.ep, e.ec, e.per, e.pv, e.zs);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] flip;
    logic       clr;
    cur = 8'h2A;
    m_reset();
    #12;
    chk("reset_outputs", int'({locked, err_pulse, err_count, period, period_vld, zero_seen}), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Clean stream: lock after the 5th sample, period 255 samples later.
    repeat (4) send(8'h00, 1'b0);
    chk("t1_unlocked_after4", int'(locked), 0);
    send(8'h00, 1'b0);
    chk("t1_locked_after5", int'(locked), 1);
    repeat (254) send(8'h00, 1'b0);
    chk("t1_no_period_early", int'(period_vld), 0);
    send(8'h00, 1'b0);
    chk("t1_period_vld", int'(period_vld), 1);
    chk("t1_period", int'(period), 255);
    chk("t1_err_count", int'(err_count), 0);

    // Single bit error is flywheeled through.
    send(8'h01, 1'b0);
    chk("t2_err_pulse", int'(err_pulse), 1);
    chk("t2_err_count", int'(err_count), 1);
    chk("t2_locked", int'(locked), 1);
    send(8'h00, 1'b0);
    chk("t2_next_matches", int'(err_pulse), 0);

    // Three consecutive errors drop lock; relock and remeasure.
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    chk("t3_locked_after2", int'(locked), 1);
    send(8'h01, 1'b0);
    chk("t3_lock_lost", int'(locked), 0);
    chk("t3_err_count", int'(err_count), 4);
    repeat (4) send(8'h00, 1'b0);
    chk("t3_not_yet_relocked", int'(locked), 0);
    send(8'h00, 1'b0);
    chk("t3_relocked", int'(locked), 1);
    repeat (254) send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    chk("t3_period_vld", int'(period_vld), 1);
    chk("t3_period", int'(period), 255);

    // Gapped valid: period still counted in valid samples.
    repeat (255) begin
      idle();
      send(8'h00, 1'b0);
    end
    chk("t4_period_vld", int'(period_vld), 1);
    chk("t4_period", int'(period), 255);
    chk("t4_err_count", int'(err_count), 4);

    send(8'h80, 1'b0);
    chk("t6_err_count5", int'(err_count), 5);

    // Async reset while locked.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_reset_async", int'({locked, err_pulse, err_count, period, period_vld, zero_seen}), 0);
    m_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;

    // All-zero lock-up word.
    repeat (6) step(1'b1, 8'h00, 1'b0);
    chk("t5_never_locked", int'(locked), 0);
    chk("t5_zero_seen", int'(zero_seen), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_zero_cleared", int'(zero_seen), 0);

    // Relock, then clear on the same cycle as an error.
    repeat (5) send(8'h00, 1'b0);
    chk("t6_relocked", int'(locked), 1);
    send(8'h10, 1'b1);
    chk("t6_clear_pulse", int'(err_pulse), 1);
    chk("t6_clear_wins", int'(err_count), 0);

    // Randomized stream: gaps, sporadic corruption, sporadic clears.
    repeat (3000) begin
      if ($urandom % 4 == 0) begin
        idle();
      end else begin
        flip = ($urandom % 24 == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        clr  = ($urandom % 64 == 0);
        send(flip, clr);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
